// File: rtl/dac_spi_pkg.sv
// Shared types and elaboration-time helpers for the daisy-chained DAC SPI controller.
package dac_spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StCsHold,
    StLdacWait,
    StLdac
  } state_e;

  localparam int unsigned MinNDev   = 1;
  localparam int unsigned MinClkDiv = 1;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered status flags and a
// one-cycle pulse on every dropped write.
module sync_fifo
  import dac_spi_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, empty_q, overflow_q;
  logic             push, pop;

  function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + AddrW'(1);
  endfunction

  assign push = wr_en && !full_q;
  assign pop  = rd_en && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q    <= count_d;
      full_q     <= (count_d == CntW'(DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= wr_en && full_q;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/dac_daisy_spi_ctrl.sv
// SPI master for a daisy chain of N_DEV DACs, one word per device per frame, followed by an
// LDAC strobe. Define DAC_READBACK_EN to add SDO capture (dac_sdo, rd_data, rd_valid).
module dac_daisy_spi_ctrl
  import dac_spi_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned N_DEV      = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CLK_DIV    = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [WORD_W-1:0]                wr_data,
  input  logic                             ldac_auto,
  input  logic                             update,
`ifdef DAC_READBACK_EN
  input  logic                             dac_sdo,
  output logic [WORD_W-1:0]                rd_data,
  output logic                             rd_valid,
`endif
  output logic                             fifo_full,
  output logic                             fifo_empty,
  output logic [cnt_width(FIFO_DEPTH)-1:0] fifo_count,
  output logic                             wr_overflow,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             dac_sck,
  output logic                             dac_cs_b,
  output logic                             dac_sdi,
  output logic                             dac_ldac_b
);

  localparam int unsigned CntW = cnt_width(FIFO_DEPTH);
  localparam int unsigned DivW = $clog2(2 * CLK_DIV);
  localparam int unsigned BitW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned WcW  = $clog2(N_DEV + 1);

  if (N_DEV < MinNDev || CLK_DIV < MinClkDiv || FIFO_DEPTH < N_DEV ||
      !is_pow2(FIFO_DEPTH)) begin : gen_param_err
    $error("dac_daisy_spi_ctrl: illegal parameter combination");
  end

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [WcW-1:0]    word_q, word_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WORD_W-1:0] fifo_head;
  logic              pop, done;
  logic              cs_b_q, sck_q, sdi_q, ldac_b_q, busy_q, done_q;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (wr_overflow)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    word_d  = word_q;
    sreg_d  = sreg_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        word_d = '0;
        if (fifo_count >= CntW'(N_DEV)) state_d = StLoad;
      end
      StLoad: begin
        pop     = 1'b1;
        sreg_d  = fifo_head;
        word_d  = word_q + WcW'(1);
        div_d   = '0;
        bit_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (div_q == DivW'(2 * CLK_DIV - 1)) begin
          div_d = '0;
          if (bit_q == BitW'(WORD_W - 1)) begin
            state_d = (word_q < WcW'(N_DEV)) ? StLoad : StCsHold;
          end else begin
            bit_d  = bit_q + BitW'(1);
            sreg_d = sreg_q << 1;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StCsHold: begin
        if (div_q == DivW'(CLK_DIV - 1)) begin
          div_d   = '0;
          state_d = ldac_auto ? StLdac : StLdacWait;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StLdacWait: begin
        if (update) begin
          div_d   = '0;
          state_d = StLdac;
        end
      end
      StLdac: begin
        if (div_q == DivW'(CLK_DIV - 1)) begin
          div_d   = '0;
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin values are decoded from the next state so each flop mirrors the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      word_q   <= '0;
      sreg_q   <= '0;
      cs_b_q   <= 1'b1;
      sck_q    <= 1'b0;
      sdi_q    <= 1'b0;
      ldac_b_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      word_q   <= word_d;
      sreg_q   <= sreg_d;
      cs_b_q   <= !((state_d == StLoad) || (state_d == StShift) || (state_d == StCsHold));
      sck_q    <= (state_d == StShift) && (div_d >= DivW'(CLK_DIV));
      sdi_q    <= (state_d == StShift) && sreg_d[WORD_W-1];
      ldac_b_q <= (state_d != StLdac);
      busy_q   <= (state_d != StIdle);
      done_q   <= done;
    end
  end

  assign dac_cs_b   = cs_b_q;
  assign dac_sck    = sck_q;
  assign dac_sdi    = sdi_q;
  assign dac_ldac_b = ldac_b_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

`ifdef DAC_READBACK_EN
  logic [WORD_W-1:0] rx_q, rx_d;
  logic              sample, word_last;

  // Sample in the first SCK-high cycle; with CLK_DIV=1 that coincides with the word end.
  always_comb begin
    sample    = (state_q == StShift) && (div_q == DivW'(CLK_DIV));
    word_last = (state_q == StShift) && (div_q == DivW'(2 * CLK_DIV - 1)) &&
                (bit_q == BitW'(WORD_W - 1));
    rx_d      = sample ? ((rx_q << 1) | WORD_W'(dac_sdo)) : rx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rx_q     <= rx_d;
      rd_valid <= word_last;
      if (word_last) rd_data <= rx_d;
    end
  end
`endif

endmodule

// File: tb/tb_dac_daisy_spi_ctrl.sv
// Directed bench for dac_daisy_spi_ctrl: scoreboarded SDI words, frame timing, LDAC modes,
// FIFO overflow and asynchronous reset; readback compared when DAC_READBACK_EN is defined.
module tb_dac_daisy_spi_ctrl;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned N_DEV      = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              ldac_auto = 1'b0;
  logic              update = 1'b0;
  logic              fifo_full, fifo_empty, wr_overflow, busy, frame_done;
  logic [CNT_W-1:0]  fifo_count;
  logic              dac_sck, dac_cs_b, dac_sdi, dac_ldac_b;
`ifdef DAC_READBACK_EN
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];
  logic [31:0] rd_sb[$];
  int words_done = 0;
  int done_cnt   = 0;
  int ovf_cnt    = 0;
  int rd_cnt     = 0;

  dac_daisy_spi_ctrl #(
    .WORD_W     (WORD_W),
    .N_DEV      (N_DEV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .ldac_auto   (ldac_auto),
    .update      (update),
`ifdef DAC_READBACK_EN
    .dac_sdo     (dac_sdi),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
`endif
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_count  (fifo_count),
    .wr_overflow (wr_overflow),
    .busy        (busy),
    .frame_done  (frame_done),
    .dac_sck     (dac_sck),
    .dac_cs_b    (dac_cs_b),
    .dac_sdi     (dac_sdi),
    .dac_ldac_b  (dac_ldac_b)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] w);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = w;
    sb.push_back(w);
    rd_sb.push_back(w);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_cs(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (dac_cs_b !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dac_cs_b === lvl), 32'd1);
  endtask

  // Counts consecutive low LDAC cycles starting at the current negedge.
  task automatic measure_ldac(output int n);
    n = 0;
    while (dac_ldac_b === 1'b0 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Monitor: rebuild words from SDI at SCK rises and compare against the scoreboard.
  initial begin
    logic [31:0] rx = '0;
    logic [31:0] exp_w;
    int          bit_n = 0;
    logic        prev_sck = 1'b0;
    logic        prev_sdi = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bit_n    = 0;
        prev_sck = 1'b0;
        prev_sdi = 1'b0;
      end else begin
        if (dac_sck) check("sdi_stable_sck_high", 32'(dac_sdi), 32'(prev_sdi));
        if (dac_sck && !prev_sck) begin
          rx = {rx[30:0], dac_sdi};
          bit_n++;
          if (bit_n == WORD_W) begin
            bit_n = 0;
            if (sb.size() == 0) begin
              check("sdi_unexpected_word", rx, 32'hxxxxxxxx);
            end else begin
              exp_w = sb.pop_front();
              check("sdi_word", rx, exp_w);
              words_done++;
            end
          end
        end
        prev_sck = dac_sck;
        prev_sdi = dac_sdi;
        if (frame_done) done_cnt++;
        if (wr_overflow) ovf_cnt++;
`ifdef DAC_READBACK_EN
        if (rd_valid) begin
          rd_cnt++;
          if (rd_sb.size() == 0) check("rd_unexpected", rd_data, 32'hxxxxxxxx);
          else begin
            exp_w = rd_sb.pop_front();
            check("rd_data", rd_data, exp_w);
          end
        end
`endif
      end
    end
  end

  initial begin
    int n;
    int snap;
    int rises;
    logic prev;
    logic [31:0] ow [5];
    ow = '{32'hDEADBEEF, 32'h0F0F0F0F, 32'hC3C3C3C3, 32'h00000001, 32'hFFFFFFFF};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs_b", 32'(dac_cs_b), 32'd1);
    check("rst_ldac_b", 32'(dac_ldac_b), 32'd1);
    check("rst_sck", 32'(dac_sck), 32'd0);
    check("rst_sdi", 32'(dac_sdi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(wr_overflow), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;

    // Update in IDLE is ignored
    @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    @(negedge clk);
    check("idle_update_busy", 32'(busy), 32'd0);
    check("idle_update_ldac", 32'(dac_ldac_b), 32'd1);

    // Threshold and auto-mode frame
    ldac_auto = 1'b1;
    write_word(32'hA5000001);
    check("thr_count1", 32'(fifo_count), 32'd1);
    check("thr_empty", 32'(fifo_empty), 32'd0);
    repeat (5) @(negedge clk);
    check("thr_idle_busy", 32'(busy), 32'd0);
    check("thr_idle_cs", 32'(dac_cs_b), 32'd1);
    write_word(32'h5A000002);
    check("thr_count2", 32'(fifo_count), 32'd2);
    check("thr_pre_load_cs", 32'(dac_cs_b), 32'd1);
    @(negedge clk);
    check("load_cs_low", 32'(dac_cs_b), 32'd0);
    check("load_busy", 32'(busy), 32'd1);
    n = 1;
    @(negedge clk);
    while (dac_cs_b === 1'b0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("auto_cs_low_cycles", n, 32'd260);
    measure_ldac(n);
    check("auto_ldac_cycles", n, 32'd2);
    check("auto_frame_done", 32'(frame_done), 32'd1);
    @(negedge clk);
    check("auto_done_single", 32'(frame_done), 32'd0);
    check("auto_idle_busy", 32'(busy), 32'd0);
    check("auto_fifo_empty", 32'(fifo_empty), 32'd1);
    check("auto_done_cnt", done_cnt, 32'd1);
    check("auto_words", words_done, 32'd2);

    // Manual mode, with the overflow test while parked in LDAC_WAIT
    ldac_auto = 1'b0;
    write_word(32'h12345678);
    write_word(32'h80000001);
    wait_cs(1'b0, 20, "man_cs_fall");
    wait_cs(1'b1, 600, "man_cs_rise");
    check("man_wait_ldac", 32'(dac_ldac_b), 32'd1);
    check("man_wait_busy", 32'(busy), 32'd1);
    snap = ovf_cnt;
    @(negedge clk);
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = ow[i];
      if (i < 4) begin
        sb.push_back(ow[i]);
        rd_sb.push_back(ow[i]);
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_pulses", ovf_cnt - snap, 32'd1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b1 && dac_ldac_b === 1'b1 && dac_cs_b === 1'b1) n++;
    end
    check("man_hold_cycles", n, 32'd100);
    snap = done_cnt;
    @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update    = 1'b0;
    ldac_auto = 1'b1;
    measure_ldac(n);
    check("man_ldac_cycles", n, 32'd2);
    check("man_frame_done", 32'(frame_done), 32'd1);

    // Next frame runs from the parked words; wait for its end
    n = 0;
    while (done_cnt < snap + 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("frame2_done", 32'(done_cnt >= snap + 2), 32'd1);

    // Reset during SHIFT bit 10 of the following frame
    wait_cs(1'b0, 20, "rstmid_cs_fall");
    rises = 0;
    prev  = dac_sck;
    n     = 0;
    while (rises < 10 && n < 500) begin
      @(negedge clk);
      if (dac_sck && !prev) rises++;
      prev = dac_sck;
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    check("rstmid_pre_busy", 32'(busy), 32'd1);
    check("rstmid_pre_cs", 32'(dac_cs_b), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_cs_b", 32'(dac_cs_b), 32'd1);
    check("rstmid_sck", 32'(dac_sck), 32'd0);
    check("rstmid_count", 32'(fifo_count), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    sb.delete();
    rd_sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_empty", 32'(fifo_empty), 32'd1);

    // Normal frame after reset
    snap = done_cnt;
    write_word(32'h00FF00FF);
    write_word(32'h7FFFFFFE);
    n = 0;
    while (done_cnt == snap && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_done", done_cnt - snap, 32'd1);
    repeat (2) @(negedge clk);
    check("final_words", words_done, 32'd8);
    check("final_sb_empty", sb.size(), 32'd0);
`ifdef DAC_READBACK_EN
    check("final_rd_cnt", rd_cnt, 32'd8);
    check("final_rd_sb_empty", rd_sb.size(), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_daisy_spi_ctrl.md
# dac_daisy_spi_ctrl

Parametrised SPI master for a daisy chain of `N_DEV` serial DACs, fed by a host endpoint through an internal single-clock FIFO. A frame is one word per device, shifted back-to-back under a single `dac_cs_b` assertion. Each frame ends with an `dac_ldac_b` update strobe, issued either automatically or on host request. The block sits between the host endpoint logic and the DAC pins, and shares the endpoint/DAC split of the existing DAC programming path.

## Interface
- `WORD_W`, 32, bits per DAC word.
- `N_DEV`, 4, DACs in the chain, which is also the number of words per frame; ≥1.
- `FIFO_DEPTH`, 16, FIFO words; power of 2, ≥ `N_DEV`.
- `CLK_DIV`, 5, clk cycles per SCK half-period; ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  push `wr_data` into the FIFO.
- `wr_data`  in  `WORD_W`  DAC word.
- `ldac_auto`  in  1  1: strobe LDAC right after the frame; 0: wait for `update`.
- `update`  in  1  single-cycle LDAC request while in LDAC_WAIT.
- `fifo_full`  out  1  FIFO full.
- `fifo_empty`  out  1  FIFO empty.
- `fifo_count`  out  `$clog2(FIFO_DEPTH+1)`  words stored.
- `wr_overflow`  out  1  one-cycle pulse when a write is dropped.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of LDAC.
- `dac_sck`  out  1  SPI clock, idles low.
- `dac_cs_b`  out  1  chip select, active-low.
- `dac_sdi`  out  1  serial data, MSB first.
- `dac_ldac_b`  out  1  DAC update strobe, active-low.

## Operation
- FIFO:
  - First-word fall-through.
  - A write while full is dropped and pulses `wr_overflow`.
  - A simultaneous push and pop leaves the count unchanged.
- States: IDLE → LOAD → SHIFT → (LOAD | CS_HOLD) → (LDAC | LDAC_WAIT → LDAC) → IDLE.
- IDLE:
  - Outputs: `dac_cs_b`=1, `dac_sck`=0, `dac_sdi`=0.
  - Goes to LOAD when `fifo_count ≥ N_DEV`.
  - A frame never starts with fewer than `N_DEV` words stored.
- LOAD (1 cycle): pops the FIFO head into the shift register, increments the word counter, and drives `dac_cs_b` low.
- SHIFT:
  - Each bit lasts `2*CLK_DIV` cycles: SCK is low for the first `CLK_DIV`, high for the second.
  - `dac_sdi` is the shift-register MSB and changes only while SCK is low.
  - After `WORD_W` bits, goes to LOAD if the word counter < `N_DEV`, else to CS_HOLD.
- Word order: the first word written goes to the farthest DAC.
- CS_HOLD: `CLK_DIV` cycles with `dac_cs_b`=0 and SCK low. `dac_cs_b` then rises and the state goes to LDAC if `ldac_auto`, else to LDAC_WAIT.
- LDAC_WAIT: holds `dac_cs_b`=1 and `busy`=1 until `update`=1.
- LDAC: `dac_ldac_b`=0 for `CLK_DIV` cycles, then `frame_done` pulses and the state returns to IDLE.
- Input sampling: `ldac_auto` is sampled at the CS_HOLD exit. `update` is ignored outside LDAC_WAIT.

## Timing
- Reset values: `dac_cs_b`=1, `dac_ldac_b`=1, `dac_sck`=0, `dac_sdi`=0, `busy`=0, `frame_done`=0, `wr_overflow`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_count`=0. The FIFO is emptied.
- Reset mid-frame forces these values immediately, with no partial-frame completion.
- All outputs are registered.
- `fifo_count` updates the cycle after `wr_en`.
- Frame start latency: LOAD begins 1 cycle after `fifo_count` reaches `N_DEV`.
- `dac_cs_b` low time: `N_DEV*(1+2*CLK_DIV*WORD_W) + CLK_DIV` cycles.
- Auto-mode cycles from the first LOAD to `frame_done`: that low time plus `CLK_DIV` + 1.
- The DAC samples SDI on SCK rising edges, giving `CLK_DIV` cycles of setup and of hold.

## Configuration
- `DAC_READBACK_EN` defined:
  - Adds input `dac_sdo` (1), plus outputs `rd_data` (`WORD_W`) and `rd_valid` (1). Both new outputs reset to 0.
  - `dac_sdo` is sampled on the clk cycle at which SCK rises.
  - At each word end, `rd_data` holds the captured word and `rd_valid` pulses for 1 cycle.
- Undefined: these ports and the capture logic are absent, with no other change.

## Structure
- Package `dac_spi_pkg`: state enum, `fifo_count` width function, parameter-check constants.
- Sub-module `sync_fifo` (parametrised width and depth; FWFT; full, empty and count outputs).

## Test plan
Settings for all scenarios: `WORD_W`=32, `N_DEV`=2, `FIFO_DEPTH`=4, `CLK_DIV`=2.
- Auto mode: write 0xA5000001 then 0x5A000002 with `ldac_auto`=1 → `dac_cs_b` low 260 cycles; SDI at SCK rises is 0xA5000001 then 0x5A000002, MSB first; `dac_ldac_b` low 2 cycles; one `frame_done`.
- Frame threshold: write 1 word → stays IDLE with `fifo_count`=1; write a 2nd → LOAD next cycle.
- Manual mode: `ldac_auto`=0 → LDAC_WAIT holds `busy`=1, `dac_ldac_b`=1 for 100 cycles; pulse `update` → `dac_ldac_b` low 2 cycles, then `frame_done`.
- Overflow: park in LDAC_WAIT, write 5 words → `fifo_full`=1, `fifo_count`=4, one `wr_overflow` pulse.
- Reset mid-frame: assert `rst` during SHIFT bit 10 → `dac_cs_b`=1, `dac_sck`=0, `fifo_count`=0 without waiting for a clk edge.
- Readback (`DAC_READBACK_EN`): loop `dac_sdi` to `dac_sdo` → `rd_data` = 0xA5000001 then 0x5A000002, each with a `rd_valid` pulse.
